// File: rtl/sha_pkg.sv
// Shared types and encodings for the SHA-256 double-hash mining sequencer.
// Holds the FSM state enum, message-source selects and H-register block phases.
package sha_pkg;

    localparam int ROUNDS_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_C1     = 3'd1,
        ST_UPD1   = 3'd2,
        ST_C2     = 3'd3,
        ST_UPD2   = 3'd4,
        ST_C3     = 3'd5,
        ST_DIGEST = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

    localparam logic [1:0] W_CHUNK1 = 2'd0;
    localparam logic [1:0] W_CHUNK2 = 2'd1;
    localparam logic [1:0] W_DIGEST = 2'd2;

    localparam logic [1:0] BLK_INIT   = 2'd0;
    localparam logic [1:0] BLK_MID    = 2'd1;
    localparam logic [1:0] BLK_FIRST  = 2'd2;
    localparam logic [1:0] BLK_RESUME = 2'd3;

    function automatic logic is_round_state(input state_e s);
        return (s == ST_C1) || (s == ST_C2) || (s == ST_C3);
    endfunction

    function automatic logic is_busy(input state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

    // Message source only matters while rounds run; other states park on chunk1.
    function automatic logic [1:0] w_sel_of(input state_e s);
        case (s)
            ST_C2:   w_sel_of = W_CHUNK2;
            ST_C3:   w_sel_of = W_DIGEST;
            default: w_sel_of = W_CHUNK1;
        endcase
    endfunction

endpackage

// File: rtl/sha_round_counter.sv
// Compression round counter: 0..ROUNDS-1 with enable and clear, wrapping to 0
// after the last round so the following non-round state already sees round 0.
module sha_round_counter #(
    parameter int ROUNDS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    output logic [$clog2(ROUNDS)-1:0] count,
    output logic                      last_round
);

    localparam int RW = $clog2(ROUNDS);
    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);
    localparam logic [RW-1:0] ONE  = RW'(1);
    localparam logic [RW-1:0] ZERO = RW'(0);

    assign last_round = (count == LAST);

    // Round index register; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= ZERO;
        end else if (clr) begin
            count <= ZERO;
        end else if (en) begin
            count <= last_round ? ZERO : (count + ONE);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/sha_mining_sequencer.sv
// Control FSM for the SHA-256 double-hash datapath: chunk1 once, then chunk2 plus
// second hash per nonce from the chunk1 midstate, until a hit or range exhaustion.
module sha_mining_sequencer
    import sha_pkg::*;
#(
    parameter int ROUNDS  = ROUNDS_DEF,
    parameter int NONCE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NONCE_W-1:0]        nonce_start,
    input  logic [NONCE_W-1:0]        nonce_end,
    input  logic                      hit,
    output logic [$clog2(ROUNDS)-1:0] round,
    output logic                      round_en,
    output logic [1:0]                w_sel,
    output logic [1:0]                block,
    output logic [NONCE_W-1:0]        nonce,
    output logic                      hash_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [NONCE_W-1:0]        found_nonce
);

    state_e               state_r;
    state_e               state_next_s;
    logic [NONCE_W-1:0]   nonce_end_r;
    logic [NONCE_W-1:0]   nonce_end_next_s;
    logic [NONCE_W-1:0]   nonce_next_s;
    logic [NONCE_W-1:0]   found_nonce_next_s;
    logic [1:0]           block_next_s;
    logic                 found_next_s;
    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic                 last_round_s;

    assign cnt_en_s = is_round_state(state_r);

    sha_round_counter #(
        .ROUNDS (ROUNDS)
    ) u_round_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr_s),
        .en         (cnt_en_s),
        .count      (round),
        .last_round (last_round_s)
    );

    // Next-state and next-value logic; abort overrides everything but reset.
    always_comb begin
        state_next_s       = state_r;
        nonce_next_s       = nonce;
        nonce_end_next_s   = nonce_end_r;
        found_next_s       = found;
        found_nonce_next_s = found_nonce;
        block_next_s       = block;
        cnt_clr_s          = 1'b0;
        if (abort) begin
            state_next_s = ST_IDLE;
            block_next_s = BLK_INIT;
            found_next_s = 1'b0;
            cnt_clr_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next_s     = ST_C1;
                        nonce_next_s     = nonce_start;
                        nonce_end_next_s = nonce_end;
                        found_next_s     = 1'b0;
                        block_next_s     = BLK_INIT;
                        cnt_clr_s        = 1'b1;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_C1: begin
                    if (last_round_s) begin
                        state_next_s = ST_UPD1;
                    end else begin
                        state_next_s = ST_C1;
                    end
                end
                ST_UPD1: begin
                    state_next_s = ST_C2;
                    block_next_s = BLK_MID;
                end
                ST_C2: begin
                    if (last_round_s) begin
                        state_next_s = ST_UPD2;
                    end else begin
                        state_next_s = ST_C2;
                    end
                end
                ST_UPD2: begin
                    state_next_s = ST_C3;
                    block_next_s = BLK_FIRST;
                end
                ST_C3: begin
                    if (last_round_s) begin
                        state_next_s = ST_DIGEST;
                    end else begin
                        state_next_s = ST_C3;
                    end
                end
                ST_DIGEST: begin
                    if (hit) begin
                        state_next_s       = ST_DONE;
                        found_next_s       = 1'b1;
                        found_nonce_next_s = nonce;
                    end else if (nonce == nonce_end_r) begin
                        state_next_s = ST_DONE;
                        found_next_s = 1'b0;
                    end else begin
                        // Wraps naturally through all-ones for descending ranges.
                        state_next_s = ST_C2;
                        nonce_next_s = nonce + NONCE_W'(1);
                        block_next_s = BLK_RESUME;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, captured range and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            nonce_end_r <= {NONCE_W{1'b0}};
            nonce       <= {NONCE_W{1'b0}};
            found       <= 1'b0;
            found_nonce <= {NONCE_W{1'b0}};
            block       <= BLK_INIT;
            round_en    <= 1'b0;
            w_sel       <= W_CHUNK1;
            hash_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            nonce_end_r <= nonce_end_next_s;
            nonce       <= nonce_next_s;
            found       <= found_next_s;
            found_nonce <= found_nonce_next_s;
            block       <= block_next_s;
            round_en    <= is_round_state(state_next_s);
            w_sel       <= w_sel_of(state_next_s);
            hash_valid  <= (state_next_s == ST_DIGEST);
            busy        <= is_busy(state_next_s);
            done        <= (state_next_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sha_mining_sequencer.sv
// Self-checking bench: a cycle-offset model of the sweep timeline predicts every
// output each cycle; directed scenarios plus randomized sweeps drive the DUT.
module tb_sha_mining_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        hit = 1'b0;
    logic [31:0] nonce_start = 32'd0;
    logic [31:0] nonce_end = 32'd0;
    logic [5:0]  round;
    logic        round_en;
    logic [1:0]  w_sel;
    logic [1:0]  block;
    logic [31:0] nonce;
    logic        hash_valid;
    logic        busy;
    logic        done;
    logic        found;
    logic [31:0] found_nonce;

    sha_mining_sequencer #(.ROUNDS(64), .NONCE_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .hit(hit),
        .round(round), .round_en(round_en), .w_sel(w_sel), .block(block),
        .nonce(nonce), .hash_valid(hash_valid), .busy(busy), .done(done),
        .found(found), .found_nonce(found_nonce)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    bit chk_en = 1'b0;
    int hit_mode = -1;   // -1 never hit, -2 random, N>=0 hit on digest index N
    int t_start = 0;
    int hv_n = 0;
    int hv_cyc [16];
    logic [31:0] hv_nonce [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         round;
        bit         ren;
        logic [1:0] wsel;
        logic [1:0] blk;
        bit         dig;
        int         d;
    } ph_t;

    // Timeline of a sweep by cycle offset k after the accepting edge (k=1 is round 0).
    function automatic ph_t phase_of(input int k);
        ph_t p;
        int j;
        int r;
        p.round = 0; p.ren = 1'b0; p.wsel = 2'd0; p.blk = 2'd0; p.dig = 1'b0; p.d = 0;
        if (k <= 64) begin
            p.ren = 1'b1; p.round = k - 1;
        end else if (k > 65) begin
            j = k - 66;
            p.d = j / 130;
            r = j % 130;
            if (r < 64) begin
                p.ren = 1'b1; p.round = r; p.wsel = 2'd1; p.blk = (p.d == 0) ? 2'd1 : 2'd3;
            end else if (r == 64) begin
                p.blk = (p.d == 0) ? 2'd1 : 2'd3;
            end else if (r < 129) begin
                p.ren = 1'b1; p.round = r - 65; p.wsel = 2'd2; p.blk = 2'd2;
            end else begin
                p.dig = 1'b1; p.blk = 2'd2;
            end
        end
        return p;
    endfunction

    int          m_mode = 0;   // 0 idle, 1 sweeping, 2 done
    int          m_k = 1;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_hi = 32'd0;
    logic        m_found = 1'b0;
    logic [31:0] m_fnonce = 32'd0;
    ph_t         cur_p;
    logic [31:0] cur_nonce;

    always_comb begin
        cur_p = phase_of(m_k);
        cur_nonce = m_lo + 32'(cur_p.d);
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0; m_found <= 1'b0; m_fnonce <= 32'd0;
        end else if (abort) begin
            m_mode <= 0; m_found <= 1'b0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode <= 1; m_k <= 1; m_lo <= nonce_start; m_hi <= nonce_end; m_found <= 1'b0;
            end
        end else if (cur_p.dig) begin
            if (hit) begin
                m_mode <= 2; m_found <= 1'b1; m_fnonce <= cur_nonce;
            end else if (cur_nonce == m_hi) begin
                m_mode <= 2;
            end else begin
                m_k <= m_k + 1;
            end
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Comparator stimulus: steered by the model at digests, noise elsewhere.
    always @(negedge clk) begin
        if (m_mode == 1 && cur_p.dig) begin
            if (hit_mode == -2) hit = ($urandom_range(0, 2) == 0);
            else hit = (cur_p.d == hit_mode);
        end else begin
            hit = ($urandom_range(0, 1) == 1);
        end
    end

    // Per-cycle compare against the model, plus hash_valid logging.
    always @(negedge clk) begin
        if (chk_en) begin
            if (hash_valid === 1'b1 && hv_n < 16) begin
                hv_cyc[hv_n] = cyc_cnt;
                hv_nonce[hv_n] = nonce;
                hv_n++;
            end
            if (m_mode == 1) begin
                chk("busy", busy, 1);
                chk("done", done, 0);
                chk("found", found, 0);
                chk("round", round, cur_p.round);
                chk("round_en", round_en, cur_p.ren);
                if (cur_p.ren) chk("w_sel", w_sel, cur_p.wsel);
                chk("block", block, cur_p.blk);
                chk("nonce", nonce, cur_nonce);
                chk("hash_valid", hash_valid, cur_p.dig);
            end else begin
                chk("busy_idle", busy, 0);
                chk("done_idle", done, (m_mode == 2));
                chk("found_idle", found, m_found);
                chk("round_idle", round, 0);
                chk("round_en_idle", round_en, 0);
                chk("hash_valid_idle", hash_valid, 0);
                chk("block_idle", block, (m_mode == 2) ? 2 : 0);
                if (m_mode == 2 && m_found) chk("found_nonce", found_nonce, m_fnonce);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [31:0] ns, input logic [31:0] ne);
        @(negedge clk);
        start = 1'b1; abort = 1'b0; nonce_start = ns; nonce_end = ne;
        t_start = cyc_cnt;
        hv_n = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // kind: 0 run to done, 1 abort, 2 abort+start, 3 reset; applied at t_start+off.
    task automatic run(input int budget, input int kind, input int off, input bit noise);
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < budget && !fin; i++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            if (kind != 0 && cyc_cnt == t_start + off) begin
                case (kind)
                    1: abort = 1'b1;
                    2: begin abort = 1'b1; start = 1'b1; end
                    default: rst = 1'b1;
                endcase
            end else if (kind != 0 && cyc_cnt >= t_start + off + 3) begin
                fin = 1'b1;
            end else if (kind == 0 && done === 1'b1) begin
                fin = 1'b1;
            end else if (noise && (kind == 0 || cyc_cnt < t_start + off)) begin
                start = ($urandom_range(0, 5) == 0);
                nonce_start = $urandom;
                nonce_end = $urandom;
            end
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        if (kind == 0) chk("done_within_budget", done, 1);
        else chk("idle_after_stop", busy, 0);
    endtask

    initial begin
        logic [31:0] ns;
        int len;
        int kind;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_round", round, 0);
        chk("reset_block", block, 0);
        chk("reset_nonce", nonce, 0);
        chk("reset_found_nonce", found_nonce, 0);
        chk("reset_done", done, 0);

        // Reset during C2 round 20.
        hit_mode = -1;
        do_start(32'h10, 32'h10);
        run(300, 3, 86, 1'b0);
        chk("rst_mid_nonce", nonce, 0);
        chk("rst_mid_block", block, 0);
        chk("rst_mid_hv_count", hv_n, 0);

        // Single-nonce range.
        do_start(32'h10, 32'h10);
        run(400, 0, 0, 1'b0);
        chk("single_hv_count", hv_n, 1);
        chk("single_hv_latency", hv_cyc[0] - t_start, 195);
        chk("single_found", found, 0);

        // Range 0x100..0x103, hit on third digest.
        hit_mode = 2;
        do_start(32'h100, 32'h103);
        run(800, 0, 0, 1'b0);
        chk("range_hv_count", hv_n, 3);
        chk("range_hv0", hv_cyc[0] - t_start, 195);
        chk("range_hv1", hv_cyc[1] - t_start, 325);
        chk("range_hv2", hv_cyc[2] - t_start, 455);
        chk("range_found", found, 1);
        chk("range_found_nonce", found_nonce, 32'h102);

        // Wrapping range.
        hit_mode = -1;
        do_start(32'hFFFFFFFE, 32'h1);
        run(900, 0, 0, 1'b0);
        chk("wrap_hv_count", hv_n, 4);
        chk("wrap_n0", hv_nonce[0], 32'hFFFFFFFE);
        chk("wrap_n1", hv_nonce[1], 32'hFFFFFFFF);
        chk("wrap_n2", hv_nonce[2], 32'h0);
        chk("wrap_n3", hv_nonce[3], 32'h1);
        chk("wrap_found", found, 0);

        // Abort with start in C3 round 10, then a fresh sweep.
        do_start(32'h20, 32'h25);
        run(400, 2, 141, 1'b0);
        chk("abort_hv_count", hv_n, 0);
        chk("abort_done", done, 0);
        chk("abort_found", found, 0);
        do_start(32'h30, 32'h30);
        chk("restart_block", block, 0);
        chk("restart_round_en", round_en, 1);
        run(400, 0, 0, 1'b0);

        // Start/range noise while busy; then a new start clears done and found.
        hit_mode = 0;
        do_start(32'h40, 32'h44);
        run(400, 0, 0, 1'b1);
        chk("noise_found", found, 1);
        chk("noise_found_nonce", found_nonce, 32'h40);
        hit_mode = -1;
        do_start(32'h50, 32'h50);
        chk("newstart_done", done, 0);
        chk("newstart_found", found, 0);
        run(400, 0, 0, 1'b0);

        // Randomized sweeps with noise and occasional abort.
        hit_mode = -2;
        for (int it = 0; it < 12; it++) begin
            ns = $urandom;
            if (it % 3 == 0) ns = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
            len = $urandom_range(0, 3);
            kind = (it % 4 == 3) ? $urandom_range(1, 2) : 0;
            do_start(ns, ns + 32'(len));
            run(900, kind, $urandom_range(2, 195 + 130 * len), 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sha_mining_sequencer.md
Name: sha_mining_sequencer

Overview:
- Control FSM for the SHA-256 double-hash datapath: drives the round counter, message-source select and the 2-bit `block` phase consumed by the H0..H7 accumulator registers.
- Sweeps a nonce range: chunk1 once, then chunk2 + second hash per nonce, reusing the chunk1 midstate.
- Samples an external target comparator at each final digest and reports the first winning nonce or range exhaustion.

Parameters:
- ROUNDS, 64, compression rounds per pass; round counter width is clog2(ROUNDS).
- NONCE_W, 32, nonce width.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; honoured only in IDLE
- abort  in  1  stop immediately, return to IDLE
- nonce_start  in  NONCE_W  first nonce, captured on accepted start
- nonce_end  in  NONCE_W  last nonce (inclusive), captured on accepted start
- hit  in  1  comparator result for the current digest; sampled only while hash_valid=1
- round  out  6  current round index 0..ROUNDS-1
- round_en  out  1  high on every compression-round cycle
- w_sel  out  2  message source: 0 header chunk1, 1 chunk2 with nonce, 2 first-hash digest
- block  out  2  phase to H registers
- nonce  out  NONCE_W  nonce under evaluation
- hash_valid  out  1  one-cycle pulse: final digest present at H outputs
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  level, held in DONE until next accepted start
- found  out  1  valid with done; 1 = winning nonce located
- found_nonce  out  NONCE_W  winning nonce, held with done

Behaviour:
- States: IDLE, C1, UPD1, C2, UPD2, C3, DIGEST, DONE.
- Reset (any state): state=IDLE. Outputs round=0, round_en=0, w_sel=0, block=0, nonce=0, hash_valid=0, busy=0, done=0, found=0, found_nonce=0.
- IDLE, start=1, abort=0:
  - capture nonce_start into nonce; capture nonce_end.
  - clear done and found; go to C1; block=0.
- C1: round_en=1, w_sel=0, round counts 0..ROUNDS-1. After round ROUNDS-1, go to UPD1.
- UPD1 (1 cycle): round_en=0, round=0, block<=1 (midstate commit); go to C2.
- C2: w_sel=1, ROUNDS cycles; go to UPD2.
- UPD2 (1 cycle): block<=2; go to C3.
- C3: w_sel=2, ROUNDS cycles; go to DIGEST.
- DIGEST (1 cycle): hash_valid=1 and hit sampled.
  - hit=1: found<=1, found_nonce<=nonce, go to DONE.
  - hit=0 and nonce==nonce_end: found<=0, go to DONE.
  - otherwise: nonce<=nonce+1 (mod 2^NONCE_W), block<=3 (restart from midstate), go to C2.
- DONE: done=1, busy=0, block holds last value. start=1 behaves exactly as start in IDLE.
- Latency, start accepted at cycle t (ROUNDS=64):
  - C1 rounds at t+1..t+64; UPD1 at t+65; C2 at t+66..t+129; UPD2 at t+130; C3 at t+131..t+194.
  - First hash_valid at t+195.
  - Each further nonce: hash_valid every 130 cycles.
- Boundary conditions:
  - nonce_end < nonce_start: sweep wraps through all-ones to 0 and stops at nonce_end.
  - nonce_end == nonce_start: exactly one digest.
  - abort, any state: next cycle IDLE, block=0, round_en=0, done=0, found=0; sweep discarded.
  - abort and start in the same cycle: abort wins, start ignored.
  - rst overrides abort and start.
  - start while busy: ignored; nonce_start/nonce_end changes while busy: ignored.
  - hit outside DIGEST: ignored.

Decomposition:
- Shared package sha_pkg: state enum, w_sel encodings (W_CHUNK1/W_CHUNK2/W_DIGEST), block phase constants (BLK_INIT=0, BLK_MID=1, BLK_FIRST=2, BLK_RESUME=3), ROUNDS default.
- One natural sub-module: sha_round_counter. Counts 0..ROUNDS-1 with enable and clear, and emits a last_round flag the FSM uses for C1/C2/C3 exit.

Test Plan:
- Reset mid-C2: assert rst at round 20 -> next cycle IDLE, all outputs 0, block=0.
- start, nonce_start=nonce_end=0x10, hit=0 -> single hash_valid at t+195; done=1, found=0; block sequence 0,1,2.
- Range 0x100..0x103, hit=1 on third digest -> hash_valid at t+195, t+325, t+455; found=1, found_nonce=0x102; block=3 during second and third C2.
- Wrap: nonce_start=0xFFFFFFFE, nonce_end=0x00000001, hit=0 -> nonce values FFFFFFFE, FFFFFFFF, 0, 1; four hash_valid pulses; then done, found=0.
- Abort at C3 round 10 while start=1 same cycle -> IDLE next cycle, no hash_valid, done=0; a later start restarts from C1 with block=0.
- start pulsed during C2 -> ignored; round/nonce unaffected; DONE then new start clears done and found.
